// File: rtl/booth_qreg_n_if.sv
// Booth Q-register bus: operand load, control, carry-in
// and the register/recode/counter status back to the FSM.
interface booth_qreg_n_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic [WIDTH-1:0] in;
  logic [1:0]       ctrl;
  logic             radix4;
  logic [1:0]       carry;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [2:0]       booth_sel;
  logic [1:0]       shift_out;
  logic [CNT_W-1:0] steps_left;
  logic             done;
  logic             mode_r4;

  modport master (
    output in, ctrl, radix4, carry,
    input  q, q_m1, booth_sel, shift_out,
    input  steps_left, done, mode_r4
  );

  modport slave (
    input  in, ctrl, radix4, carry,
    output q, q_m1, booth_sel, shift_out,
    output steps_left, done, mode_r4
  );
endinterface

// File: rtl/booth_qreg_n.sv
// Booth multiplier (Q) register: load/clear/shift/hold,
// radix-2 or radix-4 stepping, Q-1 bit, step counter.
// Ports: clk, rst_n (async, active low), bus (slave):
//   in/ctrl/radix4/carry in; q, q_m1, booth_sel,
//   shift_out, steps_left, done, mode_r4 out.
module booth_qreg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  booth_qreg_n_if.slave bus
);

  localparam logic [CNT_W-1:0] STEPS_R2 = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] STEPS_R4 = CNT_W'(WIDTH / 2);

  logic [WIDTH-1:0] q_r;
  logic             q_m1_r;
  logic [1:0]       so_r;
  logic [CNT_W-1:0] cnt_r;
  logic             r4_r;
  logic             done_w;

  logic is_load;
  logic is_clr;
  logic is_shift;

  assign done_w   = (cnt_r == '0);
  assign is_load  = (bus.ctrl == 2'b00);
  assign is_clr   = (bus.ctrl == 2'b01);
  // A shift with the counter exhausted is a no-op.
  assign is_shift = (bus.ctrl == 2'b10) && !done_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= '0;
      q_m1_r <= 1'b0;
      so_r   <= 2'b00;
      cnt_r  <= '0;
      r4_r   <= 1'b0;
    end else begin
      unique case (1'b1)
        is_load: begin
          q_r    <= bus.in;
          q_m1_r <= 1'b0;
          so_r   <= 2'b00;
          r4_r   <= bus.radix4;
          cnt_r  <= bus.radix4 ? STEPS_R4 : STEPS_R2;
        end
        is_clr: begin
          q_r    <= '0;
          q_m1_r <= 1'b0;
          so_r   <= 2'b00;
          cnt_r  <= '0;
        end
        is_shift: begin
          if (r4_r) begin
            q_r    <= {bus.carry, q_r[WIDTH-1:2]};
            q_m1_r <= q_r[1];
            so_r   <= q_r[1:0];
          end else begin
            q_r    <= {bus.carry[0], q_r[WIDTH-1:1]};
            q_m1_r <= q_r[0];
            so_r   <= {1'b0, q_r[0]};
          end
          cnt_r <= cnt_r - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.q_m1       = q_m1_r;
  assign bus.booth_sel  = {q_r[1], q_r[0], q_m1_r};
  assign bus.shift_out  = so_r;
  assign bus.steps_left = cnt_r;
  assign bus.done       = done_w;
  assign bus.mode_r4    = r4_r;

endmodule

// File: doc/booth_qreg_n.md
Name: booth_qreg_n

Overview:
- Parametrised multiplier (Q) register for the Booth datapath: load, clear, arithmetic-free logical shift with carry-in, hold.
- Generalises the 4-bit Q register:
  - WIDTH-bit storage.
  - Radix-2 (shift 1) or radix-4 (shift 2) mode.
  - Built-in Q-1 bit.
  - Booth recode window output.
  - Step counter with done flag.
- Sits between the multiplier-operand load path and the Booth control FSM; the accumulator (A) register feeds its carry inputs.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2, and even if radix-4 is ever loaded
CNT_W, $clog2(WIDTH+1), width of the step counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in  input  WIDTH  parallel load data (multiplier operand)
ctrl  input  2  00 LOAD, 01 CLEAR, 10 SHIFT, 11 HOLD
radix4  input  1  mode select, sampled only on LOAD: 0 = shift 1/step, 1 = shift 2/step
carry  input  2  bits entering at MSB end; radix-2 uses carry[0] only
q  output  WIDTH  register contents
q_m1  output  1  Booth Q-1 bit
booth_sel  output  3  {q[1], q[0], q_m1} recode window
shift_out  output  2  bits shifted out on the last SHIFT (LSB-first: [0] is the lower bit)
steps_left  output  CNT_W  remaining SHIFT steps
done  output  1  high when steps_left == 0
mode_r4  output  1  latched radix mode

Behaviour:
- All outputs are driven directly from registers or from combinational decode of registers. There is no extra cycle of lag: after an edge, q, q_m1, booth_sel and shift_out reflect that edge's operation.
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - q = 0, q_m1 = 0, shift_out = 0, steps_left = 0, mode_r4 = 0, done = 1.
  - Reset release is synchronous to clk in the surrounding design; the block needs no special handling.
- LOAD (00):
  - q <= in, q_m1 <= 0, shift_out <= 0, mode_r4 <= radix4.
  - steps_left <= WIDTH if radix4 = 0, else WIDTH/2.
- CLEAR (01):
  - q <= 0, q_m1 <= 0, shift_out <= 0, steps_left <= 0.
  - mode_r4 unchanged.
- SHIFT (10) with done = 0:
  - Radix-2:
    - q <= {carry[0], q[WIDTH-1:1]}, q_m1 <= q[0].
    - shift_out <= {1'b0, q[0]}.
    - steps_left <= steps_left - 1.
  - Radix-4:
    - q <= {carry[1], carry[0], q[WIDTH-1:2]}, q_m1 <= q[1].
    - shift_out <= q[1:0].
    - steps_left <= steps_left - 1.
- SHIFT with done = 1: ignored; every register holds. The counter never wraps below 0.
- HOLD (11): all registers hold.
- radix4 is ignored on every operation except LOAD.
- An odd WIDTH with radix4 = 1 on LOAD is illegal. The verification bench flags it with an assertion; RTL behaviour in that case is unspecified.
- done is purely combinational from steps_left.

Test Plan:
- Reset: assert rst_n low mid-cycle after a LOAD of 8'hFF → immediately (no clock) q = 0, q_m1 = 0, steps_left = 0, done = 1, mode_r4 = 0.
- Radix-2 LOAD/SHIFT:
  - LOAD in = 8'hB5, radix4 = 0 → q = 8'hB5, booth_sel = 3'b010, steps_left = 8, done = 0.
  - Then SHIFT with carry = 2'b01 → q = 8'hDA, q_m1 = 1, shift_out = 2'b01, steps_left = 7.
- Radix-4 LOAD/SHIFT:
  - LOAD in = 8'hB5, radix4 = 1 → steps_left = 4, mode_r4 = 1.
  - Then SHIFT with carry = 2'b10 → q = 8'hAD, q_m1 = 0, shift_out = 2'b01, booth_sel = 3'b010, steps_left = 3.
- Counter end:
  - Radix-2 LOAD 8'h01, then 8 SHIFTs with carry = 0 → q = 0, done = 1 after the 8th.
  - A 9th SHIFT with carry = 2'b11 → q, q_m1, shift_out and steps_left all unchanged.
- HOLD/CLEAR:
  - After LOAD 8'h3C and one radix-2 SHIFT, apply 3 HOLD cycles → q = 8'h1E, steps_left = 7, both stable.
  - Then CLEAR → q = 0, steps_left = 0, done = 1, mode_r4 unchanged.
- Reload mid-operation: radix-4 LOAD and 2 SHIFTs, then radix-2 LOAD 8'h80 → mode_r4 = 0, steps_left = 8, q_m1 = 0, shift_out = 0.
